range_sequencer: RTL and testbench
==================================

RANGE_SEQUENCER -- requirements
Module: range_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample and range width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, input FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  input  WIDTH  upstream sample.
REQ-006 SHALL have port in_last  input  1  marks final sample of a sequence.
REQ-007 SHALL have port in_valid  input  1  upstream sample/in_last valid.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept; equals !full.
REQ-009 SHALL have port out_data  output  WIDTH  sample to the range finder's data input.
REQ-010 SHALL have port out_go  output  1  first-sample strobe.
REQ-011 SHALL have port out_finish  output  1  last-sample strobe.
REQ-012 SHALL have port range_in  input  WIDTH  combinational range returned by the range finder.
REQ-013 SHALL have port result  output  WIDTH  captured range of the last completed sequence.
REQ-014 SHALL have port result_valid  output  1  one-cycle pulse when result updates.
REQ-015 SHALL have port busy  output  1  high while state != IDLE.

Function
REQ-016 SHALL store {in_data, in_last} in a DEPTH-entry FIFO on each rising edge with in_valid && in_ready; no push-through when full.
REQ-017 SHALL expose an entry to pop logic no earlier than the cycle after its write (not fall-through); minimum in-to-out latency 2 edges.
REQ-018 SHALL register out_data, out_go, out_finish; out_go and out_finish are 0 on every cycle not explicitly listed below.
REQ-019 SHALL implement FSM states IDLE, STREAM, SINGLE.
REQ-020 IDLE, FIFO non-empty: pop head, out_data<=head, out_go<=1; next state SINGLE if head.last, else STREAM.
REQ-021 STREAM, FIFO non-empty: pop head, out_data<=head; if head.last, out_finish<=1 and next IDLE, else stay.
REQ-022 STREAM, FIFO empty: no pop, out_data holds previous sample, strobes 0 (repeat leaves min/max unchanged).
REQ-023 SINGLE: out_finish<=1 with out_data held (range 0 for 1-sample sequences), next IDLE; no pop.
REQ-024 SHALL never assert out_go and out_finish in the same cycle.
REQ-025 IDLE with FIFO empty: out_data holds, strobes 0.
REQ-026 On each edge at which registered out_finish is 1: result<=range_in, result_valid<=1 for exactly the following cycle.
REQ-027 A new sequence MAY begin (out_go) in the cycle immediately after out_finish; back-to-back sequences need no gap.
REQ-028 FIFO full/empty SHALL be exact at count DEPTH/0, with pointer wrap-around modulo DEPTH; simultaneous push and pop keep count unchanged.
REQ-029 Unsigned arithmetic only; result is range_in unmodified.

Reset
REQ-030 While reset is high: state IDLE, FIFO empty, in_ready 1, out_data 0, out_go 0, out_finish 0, result 0, result_valid 0, busy 0.
REQ-031 Reset mid-sequence SHALL discard all FIFO contents and the partial sequence without asserting out_finish.

Verification
REQ-032 Push 5,9,2(last) back-to-back -> out_go with 5, then 9, then out_finish with 2; result=7, result_valid one cycle after finish.
REQ-033 Push 42(last) alone -> out_go with 42, next cycle out_finish with 42; result=0.
REQ-034 Push 10, stall 4 cycles, push 3(last) -> out_data holds 10 with strobes 0 during stall; result=7.
REQ-035 Push 9 samples, downstream idle, DEPTH=8 -> in_ready 0 after 8 writes, 9th held by upstream, all 9 delivered in order.
REQ-036 Two sequences {1,4(last)},{8,6(last)} queued -> out_go directly after first out_finish; results 3 then 2.
REQ-037 Assert reset after out_go with 3 samples queued -> outputs per REQ-030, no out_finish, no result_valid.

Source files
------------

// File: rtl/range_sequencer.sv
// rtl/range_sequencer.sv - buffers sample sequences and drives go/finish strobes into an external range finder.
// The finder's combinational range is captured as the result when the final sample is presented.
module range_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_go,
  output logic             out_finish,
  input  logic [WIDTH-1:0] range_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, SINGLE} state_t;

  state_t           state, state_next;
  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic [WIDTH-1:0] head_data;
  logic             head_last;
  logic [WIDTH-1:0] out_data_next;
  logic             out_go_next, out_finish_next;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign head_data = mem[rd_ptr][WIDTH:1];
  assign head_last = mem[rd_ptr][0];
  assign busy      = (state != IDLE);

  // Storage is unreset: an entry is only visible once count says so, one edge after its write.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {in_data, in_last};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_next      = state;
    pop             = 1'b0;
    out_data_next   = out_data;
    out_go_next     = 1'b0;
    out_finish_next = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop           = 1'b1;
          out_data_next = head_data;
          out_go_next   = 1'b1;
          state_next    = head_last ? SINGLE : STREAM;
        end
      end
      STREAM: begin
        // An empty FIFO just repeats the held sample, which leaves min/max untouched.
        if (!empty) begin
          pop           = 1'b1;
          out_data_next = head_data;
          if (head_last) begin
            out_finish_next = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      SINGLE: begin
        out_finish_next = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      out_data     <= '0;
      out_go       <= 1'b0;
      out_finish   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_next;
      out_data     <= out_data_next;
      out_go       <= out_go_next;
      out_finish   <= out_finish_next;
      result_valid <= out_finish;
      if (out_finish) result <= range_in;
    end
  end

endmodule

// File: tb/tb_range_sequencer.sv
// tb/tb_range_sequencer.sv - scoreboard bench for range_sequencer with a behavioural min/max range finder.
module tb_range_sequencer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_go, out_finish;
  logic [WIDTH-1:0] range_in;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             busy;

  always #5 clock = ~clock;

  range_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_go(out_go), .out_finish(out_finish),
    .range_in(range_in), .result(result), .result_valid(result_valid), .busy(busy)
  );

  // Downstream range finder: tracks min/max since the last go strobe, including the presented sample.
  logic [WIDTH-1:0] rf_min = '0, rf_max = '0, rf_lo, rf_hi;
  always @(posedge clock) begin
    if (out_go) begin
      rf_min <= out_data;
      rf_max <= out_data;
    end else begin
      if (out_data < rf_min) rf_min <= out_data;
      if (out_data > rf_max) rf_max <= out_data;
    end
  end
  assign rf_lo    = out_go ? out_data : ((out_data < rf_min) ? out_data : rf_min);
  assign rf_hi    = out_go ? out_data : ((out_data > rf_max) ? out_data : rf_max);
  assign range_in = rf_hi - rf_lo;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             go;
    logic             fin;
    logic             pop;
  } evt_t;

  evt_t             exp_evt[$];
  logic [WIDTH-1:0] exp_res[$];
  logic [WIDTH-1:0] seq_samples[$];
  int               checks = 0;
  int               errors = 0;
  int               acc_cnt = 0;
  int               pop_cnt = 0;
  logic [WIDTH-1:0] last_sent = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: each accepted sample yields its presentation events; a sequence's result is max-min.
  task automatic model_push(input logic [WIDTH-1:0] d, input logic l);
    evt_t             e;
    logic [WIDTH-1:0] mn, mx;
    e.data = d;
    e.pop  = 1'b1;
    e.go   = (seq_samples.size() == 0);
    e.fin  = l && !e.go;
    exp_evt.push_back(e);
    if (l && e.go) begin
      e.go  = 1'b0;
      e.fin = 1'b1;
      e.pop = 1'b0;
      exp_evt.push_back(e);
    end
    seq_samples.push_back(d);
    if (l) begin
      mn = seq_samples[0];
      mx = seq_samples[0];
      foreach (seq_samples[i]) begin
        if (seq_samples[i] < mn) mn = seq_samples[i];
        if (seq_samples[i] > mx) mx = seq_samples[i];
      end
      exp_res.push_back(mx - mn);
      seq_samples.delete();
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int t = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      @(posedge clock); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
    end else begin
      @(posedge clock); #1;
      in_valid = 1'b0;
      acc_cnt++;
      last_sent = d;
      model_push(d, l);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_evt.size() != 0 || exp_res.size() != 0) && t < 300) begin
      @(posedge clock); #1;
      t++;
    end
    check("drain_pending", exp_evt.size() + exp_res.size(), 0);
    idle_cycles(2);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_go"}, out_go, 0);
    check({tag, "_out_finish"}, out_finish, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: an output event is a strobe, or a new sample while busy (stimulus never repeats a value back-to-back).
  logic [WIDTH-1:0] prev_data = '0;
  logic             prev_fin = 1'b0;
  logic             b2b_seen = 1'b0;
  logic             full_seen = 1'b0;
  evt_t             mon_e;
  always @(negedge clock) begin
    if (reset) begin
      prev_data = out_data;
      prev_fin  = 1'b0;
    end else begin
      if (out_go || out_finish || (busy && out_data != prev_data)) begin
        if (exp_evt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=data %0d go %0b finish %0b required=no_output", out_data, out_go, out_finish);
        end else begin
          mon_e = exp_evt.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_go", out_go, mon_e.go);
          check("out_finish", out_finish, mon_e.fin);
          if (mon_e.pop) pop_cnt++;
        end
      end
      if (out_go && prev_fin) b2b_seen = 1'b1;
      prev_fin = out_finish;
      if (out_go && out_finish) check("go_finish_exclusive", {out_go, out_finish}, 2'b00);
      if (result_valid) begin
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0d required=no_result_valid", result);
        end else begin
          check("result", result, exp_res.pop_front());
        end
      end
      if (!in_ready) full_seen = 1'b1;
      check("in_ready_vs_occupancy", in_ready, (acc_cnt - pop_cnt) < DEPTH);
      prev_data = out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] v;
    int               len;

    #12;
    check_reset_values("reset");
    @(posedge clock); #1;
    reset = 1'b0;
    idle_cycles(2);

    // 5,9,2: not fall-through, so go appears only after the second edge.
    send(16'd5, 1'b0);
    check("latency_no_go_yet", out_go, 0);
    send(16'd9, 1'b0);
    check("latency_go", out_go, 1);
    check("latency_go_data", out_data, 5);
    send(16'd2, 1'b1);
    wait_drain();

    send(16'd42, 1'b1);
    idle_cycles(1);
    check("single_go", {out_go, out_finish}, 2'b10);
    check("single_go_data", out_data, 42);
    idle_cycles(1);
    check("single_finish", {out_go, out_finish}, 2'b01);
    check("single_finish_data", out_data, 42);
    wait_drain();

    send(16'd10, 1'b0);
    idle_cycles(4);
    check("stall_data", out_data, 10);
    check("stall_strobes", {out_go, out_finish}, 2'b00);
    check("stall_busy", busy, 1);
    send(16'd3, 1'b1);
    wait_drain();

    b2b_seen = 1'b0;
    send(16'd1, 1'b0);
    send(16'd4, 1'b1);
    send(16'd8, 1'b0);
    send(16'd6, 1'b1);
    wait_drain();
    check("back_to_back_go", b2b_seen, 1);

    // Single-sample sequences drain at half rate, so a continuous push fills the FIFO.
    full_seen = 1'b0;
    for (int i = 0; i < 20; i++) send(16'(100 + i), 1'b1);
    wait_drain();
    check("fifo_full_seen", full_seen, 1);

    for (int s = 0; s < 30; s++) begin
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        do v = WIDTH'($urandom_range(1, 65535)); while (v == last_sent);
        send(v, i == len - 1);
      end
    end
    wait_drain();

    // Reset mid-sequence: partial data is discarded, no finish and no result follow.
    send(16'd21, 1'b0);
    send(16'd22, 1'b0);
    send(16'd23, 1'b0);
    send(16'd24, 1'b0);
    reset = 1'b1;
    #2;
    check_reset_values("midseq_reset");
    exp_evt.delete();
    exp_res.delete();
    seq_samples.delete();
    acc_cnt = 0;
    pop_cnt = 0;
    @(posedge clock); #1;
    check("midseq_reset_held_busy", busy, 0);
    reset = 1'b0;
    idle_cycles(10);
    check("post_reset_idle", {busy, out_finish, result_valid}, 3'b000);
    send(16'd50, 1'b0);
    send(16'd60, 1'b1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
